cell_select_enc: RTL and testbench

- Player-input front end for the Minesweeper datapath.
- Tracks a cursor on the 5x5 board from single-cycle button pulses and encodes the cursor position into the 5-bit cell index consumed by the datapath (data/load). The datapath then decodes that index to one-hot.
- Sequences each selection against the datapath's done handshake, rejects re-selection of already-cleared cells, and locks out input after a game ends until the next mine placement.

---
 rtl/cell_select_enc.sv | 152 +++++++++++++++
 tb/tb_cell_select_enc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cell_select_enc.sv
// Player-input front end for the Minesweeper datapath: it tracks the cursor, encodes the cell
// index, and sequences each selection against the datapath's done handshake.
//
// state  | meaning
// IDLE   | after reset; waits for the first mine placement
// READY  | accepts moves and selections
// LOAD   | one-cycle load strobe to the datapath
// WAIT   | waits for display_done (bounded by TIMEOUT); moves are still accepted
// LOCKED | game over; all input is ignored until the next mine placement
module cell_select_enc #(
  parameter int GRID_W  = 5,
  parameter int GRID_H  = 5,
  parameter int IDX_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                       clka,
  input  logic                       restart,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_sel,
  input  logic [GRID_W*GRID_H-1:0]   cleared,
  input  logic                       place_done,
  input  logic                       display_done,
  input  logic                       gameover,
  output logic [IDX_W-1:0]           data,
  output logic                       load,
  output logic                       busy,
  output logic                       locked,
  output logic                       reject,
  output logic                       err,
  output logic [2:0]                 cursor_row,
  output logic [2:0]                 cursor_col,
  output logic [GRID_W*GRID_H-1:0]   cursor_onehot,
  output logic [7:0]                 sel_count
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_LOAD,
    S_WAIT,
    S_LOCKED
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic [IDX_W-1:0] cur_idx;
  logic             sel_go, sel_rej, new_game, timeout, mv_en;

  assign cur_idx       = IDX_W'(cursor_row) * IDX_W'(GRID_W) + IDX_W'(cursor_col);
  assign cursor_onehot = {{(CELLS-1){1'b0}}, 1'b1} << cur_idx;

  // A select in READY consumes the cycle even when it is rejected, so moves are dropped.
  assign mv_en = ((state == S_READY) && !btn_sel) || (state == S_WAIT);

  always_ff @(negedge clka) begin
    if (restart) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_go    = 1'b0;
    sel_rej   = 1'b0;
    new_game  = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE, S_LOCKED: begin
        if (place_done) begin
          new_game  = 1'b1;
          state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (btn_sel) begin
          if (cleared[cur_idx]) begin
            sel_rej = 1'b1;
          end else begin
            sel_go    = 1'b1;
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (display_done) begin
          state_nxt = gameover ? S_LOCKED : S_READY;
        end else if (timer == TMR_W'(1)) begin
          timeout   = 1'b1;
          state_nxt = S_READY;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The timer is loaded on entry to WAIT, so WAIT lasts at most TIMEOUT cycles.
  always_ff @(negedge clka) begin
    if (restart) begin
      timer <= '0;
    end else if ((state_nxt == S_WAIT) && (state != S_WAIT)) begin
      timer <= TMR_W'(TIMEOUT);
    end else if ((state == S_WAIT) && (timer != '0)) begin
      timer <= timer - TMR_W'(1);
    end
  end

  always_ff @(negedge clka) begin
    if (restart) begin
      data       <= '0;
      load       <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b1;
      reject     <= 1'b0;
      err        <= 1'b0;
      cursor_row <= '0;
      cursor_col <= '0;
      sel_count  <= '0;
    end else begin
      load   <= (state_nxt == S_LOAD);
      busy   <= (state_nxt == S_LOAD) || (state_nxt == S_WAIT);
      locked <= (state_nxt == S_IDLE) || (state_nxt == S_LOCKED);
      reject <= sel_rej;
      if (timeout) err <= 1'b1;
      if (sel_go) begin
        data <= cur_idx;
        if (sel_count != 8'hFF) sel_count <= sel_count + 8'd1;
      end
      if (new_game) begin
        cursor_row <= '0;
        cursor_col <= '0;
        sel_count  <= '0;
      end else if (mv_en) begin
        if (btn_up) begin
          cursor_row <= (cursor_row == 3'd0) ? 3'(GRID_H - 1) : cursor_row - 3'd1;
        end else if (btn_down) begin
          cursor_row <= (cursor_row == 3'(GRID_H - 1)) ? 3'd0 : cursor_row + 3'd1;
        end else if (btn_left) begin
          cursor_col <= (cursor_col == 3'd0) ? 3'(GRID_W - 1) : cursor_col - 3'd1;
        end else if (btn_right) begin
          cursor_col <= (cursor_col == 3'(GRID_W - 1)) ? 3'd0 : cursor_col + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cell_select_enc.sv
// Directed bench for cell_select_enc: expected loads and rejects are queued by the stimulus
// and checked by an independent monitor.
module tb_cell_select_enc;

  logic        clka = 1'b0;
  logic        restart, btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [24:0] cleared;
  logic        place_done, display_done, gameover;
  logic [4:0]  data;
  logic        load, busy, locked, reject, err;
  logic [2:0]  cursor_row, cursor_col;
  logic [24:0] cursor_onehot;
  logic [7:0]  sel_count;

  typedef struct {
    logic [4:0] idx;
    logic [7:0] cnt;
  } exp_t;

  exp_t       load_q[$];
  logic [7:0] rej_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  cell_select_enc dut (
    .clka(clka), .restart(restart),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel),
    .cleared(cleared), .place_done(place_done),
    .display_done(display_done), .gameover(gameover),
    .data(data), .load(load), .busy(busy), .locked(locked),
    .reject(reject), .err(err),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .cursor_onehot(cursor_onehot), .sel_count(sel_count)
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after posedge; the DUT acts on the following negedge.
  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic clr_btn();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_locked"}, locked, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_reject"}, reject, 0);
    chk({tag, "_row"}, cursor_row, 0);
    chk({tag, "_col"}, cursor_col, 0);
    chk({tag, "_cnt"}, sel_count, 0);
  endtask

  always @(posedge clka) begin
    if (load) begin
      if (load_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_load: data %0d", data);
      end else begin
        exp_t e;
        e = load_q.pop_front();
        chk("load_data", data, e.idx);
        chk("load_cnt", sel_count, e.cnt);
      end
    end
    if (reject) begin
      if (rej_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_reject: cnt %0d", sel_count);
      end else begin
        chk("reject_cnt", sel_count, rej_q.pop_front());
      end
    end
  end

  initial begin
    int k;
    restart = 1; clr_btn(); cleared = '0;
    place_done = 0; display_done = 0; gameover = 0;
    step(); step();
    restart = 0;
    chk_reset_vals("rst");

    place_done = 1; step(); place_done = 0;
    chk("start_locked", locked, 0);
    chk("start_row", cursor_row, 0);
    chk("start_cnt", sel_count, 0);

    load_q.push_back('{idx: 5'd0, cnt: 8'd1});
    btn_sel = 1; step(); clr_btn();
    chk("sel0_load", load, 1);
    chk("sel0_busy", busy, 1);
    step();
    chk("sel0_load_off", load, 0);
    chk("sel0_wait_busy", busy, 1);
    display_done = 1; step(); display_done = 0;
    chk("sel0_done_busy", busy, 0);

    btn_up = 1; step(); clr_btn();
    btn_left = 1; step(); clr_btn();
    chk("wrap_row", cursor_row, 4);
    chk("wrap_col", cursor_col, 4);
    chk("wrap_onehot", cursor_onehot, 32'h100_0000);
    load_q.push_back('{idx: 5'd24, cnt: 8'd2});
    btn_sel = 1; step(); clr_btn();
    step();
    display_done = 1; step(); display_done = 0;

    btn_down = 1; step(); step(); clr_btn();
    btn_left = 1; step(); clr_btn();
    chk("mv_row", cursor_row, 1);
    chk("mv_col", cursor_col, 3);
    cleared = 25'd1 << 8;
    rej_q.push_back(8'd2);
    btn_sel = 1; step(); clr_btn();
    chk("rej_pulse", reject, 1);
    chk("rej_busy", busy, 0);
    step();
    chk("rej_one_cycle", reject, 0);
    chk("rej_cnt", sel_count, 2);
    cleared = '0;

    load_q.push_back('{idx: 5'd8, cnt: 8'd3});
    btn_sel = 1; btn_down = 1; step(); clr_btn();
    chk("prio_row", cursor_row, 1);
    step();
    btn_sel = 1; step(); clr_btn();
    chk("wait_sel_busy", busy, 1);
    chk("wait_sel_data", data, 8);
    btn_right = 1; display_done = 1; gameover = 1; step();
    clr_btn(); display_done = 0; gameover = 0;
    chk("go_locked", locked, 1);
    chk("go_move_col", cursor_col, 4);

    btn_sel = 1; step(); clr_btn();
    btn_right = 1; step(); clr_btn();
    chk("lock_col", cursor_col, 4);
    chk("lock_cnt", sel_count, 3);
    chk("lock_busy", busy, 0);
    place_done = 1; step(); place_done = 0;
    chk("new_row", cursor_row, 0);
    chk("new_col", cursor_col, 0);
    chk("new_cnt", sel_count, 0);
    chk("new_locked", locked, 0);

    btn_up = 1; btn_down = 1; step(); clr_btn();
    btn_left = 1; btn_right = 1; step(); clr_btn();
    chk("prio_ud", cursor_row, 4);
    chk("prio_lr", cursor_col, 4);

    load_q.push_back('{idx: 5'd24, cnt: 8'd1});
    btn_sel = 1; step(); clr_btn();
    k = 0;
    while (!err && k < 100) begin
      step();
      k++;
    end
    chk("tmo_cycles", k, 65);
    chk("tmo_busy", busy, 0);
    chk("tmo_locked", locked, 0);

    load_q.push_back('{idx: 5'd24, cnt: 8'd2});
    btn_sel = 1; step(); clr_btn();
    step();
    chk("pre_rst_busy", busy, 1);
    restart = 1; step(); restart = 0;
    chk_reset_vals("midrst");

    step();
    chk("load_q_empty", load_q.size(), 0);
    chk("rej_q_empty", rej_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: sim time %0t", $time);
    $fatal(1, "bench timed out");
  end

endmodule
